// File: rtl/mpc_f2_vector_stream_reader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mpc_f2_vector_stream_reader: streams f2_V[0..DEPTH-1] from BRAM via a
// credit-limited 2-entry buffer under ap_ctrl_hs control.   Rev 1.0
// ---------------------------------------------------------------------------
module mpc_f2_vector_stream_reader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 8
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              ap_start,
  output logic              ap_done,
  output logic              ap_idle,
  output logic              ap_ready,
  output logic [ADDR_W-1:0] f2_V_address0,
  output logic              f2_V_ce0,
  input  logic [DATA_W-1:0] f2_V_q0,
  output logic [DATA_W-1:0] m_tdata,
  output logic [ADDR_W-1:0] m_tindex,
  output logic              m_tlast,
  output logic              m_tvalid,
  input  logic              m_tready
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int ENT_W = DATA_W + ADDR_W + 1;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] inflight_idx_q, inflight_idx_d;
  logic [1:0]        occ_q, occ_d;
  logic [ENT_W-1:0]  ent0_q, ent0_d;
  logic [ENT_W-1:0]  ent1_q, ent1_d;

  logic              w_pop;
  logic              w_issue;
  logic [2:0]        w_credit;
  logic [ENT_W-1:0]  w_new;

  always_comb begin
    w_pop    = (occ_q != 2'd0) && m_tready;
    // Occupancy plus in-flight read, net of this cycle's pop, must leave a free slot.
    w_credit = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, w_pop};
    w_issue  = (state_q == S_RUN) && (w_credit < 3'd2);
    w_new    = {f2_V_q0, inflight_idx_q, (inflight_idx_q == LAST_IDX)};

    state_d        = state_q;
    cnt_d          = cnt_q;
    inflight_d     = w_issue;
    inflight_idx_d = cnt_q[ADDR_W-1:0];

    case (state_q)
      S_IDLE: begin
        if (ap_start) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        if (w_issue) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_pop && ent0_q[0]) state_d = S_DONE;
      end
      default: begin
        // A held ap_start chains straight into the next run.
        if (ap_start) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase

    occ_d  = occ_q;
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    case ({inflight_q, w_pop})
      2'b10: begin
        if (occ_q == 2'd0) ent0_d = w_new;
        else               ent1_d = w_new;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        ent0_d = ent1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          ent0_d = w_new;
        end else begin
          ent0_d = ent1_q;
          ent1_d = w_new;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      inflight_q     <= 1'b0;
      inflight_idx_q <= '0;
      occ_q          <= 2'd0;
      ent0_q         <= '0;
      ent1_q         <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      inflight_q     <= inflight_d;
      inflight_idx_q <= inflight_idx_d;
      occ_q          <= occ_d;
      ent0_q         <= ent0_d;
      ent1_q         <= ent1_d;
    end
  end

  assign f2_V_ce0      = w_issue;
  assign f2_V_address0 = cnt_q[ADDR_W-1:0];
  assign m_tvalid      = (occ_q != 2'd0);
  assign m_tdata       = ent0_q[ENT_W-1 -: DATA_W];
  assign m_tindex      = ent0_q[ADDR_W:1];
  assign m_tlast       = ent0_q[0];
  assign ap_done       = (state_q == S_DONE);
  assign ap_ready      = (state_q == S_DONE);
  assign ap_idle       = (state_q == S_IDLE) && !ap_start;

endmodule
`default_nettype wire

// File: tb/tb_mpc_f2_vector_stream_reader.sv
`default_nettype none
// Bench for mpc_f2_vector_stream_reader: scoreboarded stream checks plus
// cycle-exact latency, backpressure, chaining, reset-abort and DEPTH=1 runs.
module tb_mpc_f2_vector_stream_reader;

  localparam int DW = 32;
  localparam int AW = 3;
  localparam int D  = 8;

  logic          clk = 1'b0;
  logic          rst_n, start, done, idle, rdy, ce0, tlast, tvalid, tready;
  logic [AW-1:0] addr, tindex;
  logic [DW-1:0] q0, tdata;

  logic          d1_start, d1_done, d1_idle, d1_rdy, d1_ce0, d1_tlast, d1_tvalid;
  logic          d1_tready;
  logic [AW-1:0] d1_addr, d1_tindex;
  logic [DW-1:0] d1_q0, d1_tdata;

  logic [DW-1:0] mem [0:D-1];

  int n_checks = 0;
  int n_errors = 0;
  int issues = 0;
  int pops = 0;
  int beats = 0;
  int mode = 0;
  logic [DW+AW:0] sb [$];

  always #5 clk = ~clk;

  mpc_f2_vector_stream_reader #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(D)) u_dut (
    .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(start), .ap_done(done),
    .ap_idle(idle), .ap_ready(rdy), .f2_V_address0(addr), .f2_V_ce0(ce0),
    .f2_V_q0(q0), .m_tdata(tdata), .m_tindex(tindex), .m_tlast(tlast),
    .m_tvalid(tvalid), .m_tready(tready)
  );

  mpc_f2_vector_stream_reader #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(1)) u_dut1 (
    .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(d1_start), .ap_done(d1_done),
    .ap_idle(d1_idle), .ap_ready(d1_rdy), .f2_V_address0(d1_addr), .f2_V_ce0(d1_ce0),
    .f2_V_q0(d1_q0), .m_tdata(d1_tdata), .m_tindex(d1_tindex), .m_tlast(d1_tlast),
    .m_tvalid(d1_tvalid), .m_tready(d1_tready)
  );

  always @(posedge clk) begin
    if (ce0)    q0    <= mem[addr];
    if (d1_ce0) d1_q0 <= mem[d1_addr];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_run();
    logic [DW+AW:0] e;
    for (int i = 0; i < D; i++) begin
      e = {mem[i], AW'(i), (i == D - 1)};
      sb.push_back(e);
    end
  endtask

  task automatic start_pulse();
    @(posedge clk); #1;
    start = 1'b1;
    push_run();
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < bound && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("done_timeout", seen, 1);
  endtask

  // Scoreboard monitor: head of stream must match the oldest expectation every valid cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ce0) begin
        chk("credit", ((issues - pops - ((tvalid && tready) ? 1 : 0)) < 2), 1);
        issues++;
      end
      if (tvalid) begin
        if (sb.size() == 0) chk("sb_underflow", 1, 0);
        else                chk("head", {tdata, tindex, tlast}, sb[0]);
        if (tready) begin
          if (sb.size() != 0) void'(sb.pop_front());
          pops++;
          beats++;
        end
      end
    end
  end

  initial begin
    tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (mode)
        1:       tready = ~tready;
        2:       tready = 1'b0;
        default: tready = 1'b1;
      endcase
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int b0, i0;
    bit seen;
    rst_n = 1'b0; start = 1'b0; d1_start = 1'b0; d1_tready = 1'b1;
    for (int i = 0; i < D; i++) mem[i] = 32'h1111_1111 * i;
    repeat (3) @(posedge clk); #1;
    chk("rst_valid", tvalid, 0);
    chk("rst_ce0", ce0, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", rdy, 0);
    chk("rst_idle", idle, 1);
    chk("rst_tdata", tdata, 0);
    rst_n = 1'b1;

    // T1: cycle-exact full-rate run
    @(posedge clk); #1;
    start = 1'b1;
    push_run();
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk);
      chk("t1_ce0", ce0, (k >= 1 && k <= 8));
      if (ce0) chk("t1_addr", addr, k - 1);
      chk("t1_valid", tvalid, (k >= 3 && k <= 10));
      chk("t1_last", tvalid && tlast, (k == 10));
      chk("t1_done", done, (k == 11));
      chk("t1_ready", rdy, (k == 11));
      chk("t1_idle", idle, (k == 12));
      @(posedge clk); #1;
      if (k == 0) start = 1'b0;
    end
    chk("t1_sb_empty", sb.size(), 0);

    // T2: alternating backpressure
    mode = 1;
    b0 = beats;
    start_pulse();
    wait_done(100);
    #1;
    chk("t2_beats", beats - b0, 8);
    chk("t2_sb_empty", sb.size(), 0);

    // T3: stall right from the first valid
    mode = 2;
    @(posedge clk); #2;
    i0 = issues;
    start_pulse();
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (tvalid) seen = 1'b1;
    end
    chk("t3_valid_seen", seen, 1);
    repeat (6) @(negedge clk);
    #1;
    chk("t3_tindex", tindex, 0);
    chk("t3_tdata", tdata, mem[0]);
    chk("t3_issues", issues - i0, 2);
    mode = 0;
    wait_done(100);
    chk("t3_sb_empty", sb.size(), 0);

    // T4: ap_start held across two runs
    b0 = beats;
    @(posedge clk); #1;
    start = 1'b1;
    push_run();
    push_run();
    wait_done(100);
    chk("t4_idle_done", idle, 0);
    @(negedge clk);
    chk("t4_ce0", ce0, 1);
    chk("t4_addr", addr, 0);
    chk("t4_idle_run", idle, 0);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(100);
    #1;
    chk("t4_beats", beats - b0, 16);
    chk("t4_sb_empty", sb.size(), 0);

    // T5: reset after beat 3, then a clean restart
    for (int i = 0; i < D; i++) mem[i] = 32'hA500_0000 + i;
    b0 = beats;
    start_pulse();
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(posedge clk); #1;
      if (beats - b0 >= 4) seen = 1'b1;
    end
    chk("t5_beat3_seen", seen, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_valid_async", tvalid, 0);
    chk("t5_ce0_async", ce0, 0);
    chk("t5_done_async", done, 0);
    sb.delete();
    issues = 0;
    pops = 0;
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t5_no_done", done, 0);
      chk("t5_idle", idle, 1);
    end
    b0 = beats;
    start_pulse();
    wait_done(100);
    #1;
    chk("t5_beats", beats - b0, 8);
    chk("t5_sb_empty", sb.size(), 0);

    // T6: extreme values bit-exact, then the DEPTH=1 build
    mem[0] = 32'h8000_0000; mem[1] = 32'h7FFF_FFFF; mem[2] = 32'h0000_0000;
    mem[3] = 32'hFFFF_FFFF; mem[4] = 32'h0000_0001; mem[5] = 32'hFFFF_FFFE;
    mem[6] = 32'h1234_5678; mem[7] = 32'h8765_4321;
    start_pulse();
    wait_done(100);
    chk("t6_sb_empty", sb.size(), 0);

    @(posedge clk); #1;
    d1_start = 1'b1;
    @(posedge clk); #1;
    d1_start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (d1_tvalid) seen = 1'b1;
    end
    chk("d1_valid_seen", seen, 1);
    chk("d1_tdata", d1_tdata, 32'h8000_0000);
    chk("d1_tindex", d1_tindex, 0);
    chk("d1_tlast", d1_tlast, 1);
    @(negedge clk);
    chk("d1_valid_after", d1_tvalid, 0);
    chk("d1_done", d1_done, 1);
    chk("d1_ready", d1_rdy, 1);
    @(negedge clk);
    chk("d1_idle", d1_idle, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
